// File: rtl/wb_select_stage_if.sv
// Bus bundle for wb_select_stage.
// The upstream beat handshake, the downstream beat handshake and the error counter travel together here.
interface wb_select_stage_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 5,
    parameter int SELW  = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [SELW-1:0]       in_sel;
    logic [NSRC*WIDTH-1:0] in_src;
    logic [4:0]            in_rd;
    logic                  in_we;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [4:0]            out_rd;
    logic                  out_we;
    logic                  out_illegal;
    logic [7:0]            err_cnt;

    modport slave (
        input  in_valid, in_sel, in_src, in_rd, in_we, out_ready,
        output in_ready, out_valid, out_data, out_rd, out_we, out_illegal, err_cnt
    );

    modport master (
        output in_valid, in_sel, in_src, in_rd, in_we, out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_we, out_illegal, err_cnt
    );
endinterface

// File: rtl/wb_select_stage.sv
// Writeback select stage: picks one of NSRC sources at accept time and buffers the
// result in a main + skid register pair, so in_ready never depends combinationally on out_ready.
module wb_select_stage #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 5,
    parameter int SELW  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    wb_select_stage_if.slave    bus
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [4:0]       rd;
        logic             we;
        logic             ill;
    } beat_t;

    beat_t      main_q, main_d, skid_q, skid_d, new_beat;
    logic       main_valid_q, main_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       accept, drain, legal;

    assign accept = bus.in_valid && !skid_valid_q && !flush;
    assign drain  = main_valid_q && bus.out_ready;

    // Out-of-range selects resolve to zero data with the write suppressed.
    always_comb begin
        new_beat = '0;
        legal    = (int'(bus.in_sel) < NSRC);
        for (int i = 0; i < NSRC; i++) begin
            if (int'(bus.in_sel) == i) begin
                new_beat.data = bus.in_src[i*WIDTH +: WIDTH];
            end
        end
        new_beat.rd  = bus.in_rd;
        new_beat.we  = bus.in_we && (bus.in_rd != 5'd0) && legal;
        new_beat.ill = !legal;
    end

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        err_cnt_d    = err_cnt_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            // The skid beat is older than anything arriving now, so it moves up first.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_d       = new_beat;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = new_beat;
        end
        if (accept && new_beat.ill && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            err_cnt_q    <= 8'd0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.in_ready    = !skid_valid_q;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_data    = main_q.data;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_we      = main_q.we;
    assign bus.out_illegal = main_q.ill;
    assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: a scoreboard queue holds the expected beats
// and a negedge monitor pops and compares them as the stage delivers.
module tb_wb_select_stage;
    localparam int WIDTH = 32;
    localparam int NSRC  = 5;
    localparam int SELW  = 3;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [4:0]       rd;
        logic             we;
        logic             ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    exp_t scoreboard[$];
    exp_t monExp;
    exp_t prevOut;
    logic prevStall = 1'b0;
    int   checkCount = 0;
    int   errorCount = 0;
    int   popCount = 0;
    int   popBase;
    logic [NSRC*WIDTH-1:0] src, srcA, srcB, srcC;

    always #5 clk = ~clk;

    wb_select_stage_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) bus ();

    wb_select_stage #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [NSRC*WIDTH-1:0] randSrc();
        logic [NSRC*WIDTH-1:0] r;
        for (int i = 0; i < NSRC; i++) r[i*WIDTH +: WIDTH] = $urandom;
        return r;
    endfunction

    // Drives one beat now and records the expected result if the stage will take it.
    task automatic driveBeat(input logic valid, input logic [SELW-1:0] sel, input logic [4:0] rd,
                             input logic we, input logic [NSRC*WIDTH-1:0] s, input logic flushVal);
        exp_t e;
        bus.in_valid = valid;
        bus.in_sel   = sel;
        bus.in_rd    = rd;
        bus.in_we    = we;
        bus.in_src   = s;
        flush        = flushVal;
        if (valid && bus.in_ready && !flushVal) begin
            e.ill  = (int'(sel) >= NSRC);
            e.data = e.ill ? '0 : s[int'(sel)*WIDTH +: WIDTH];
            e.rd   = rd;
            e.we   = we && (rd != 5'd0) && !e.ill;
            scoreboard.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [SELW-1:0] sel, input logic [4:0] rd,
                                 input logic we, input logic [NSRC*WIDTH-1:0] s, input logic flushVal);
        @(posedge clk);
        #1;
        driveBeat(valid, sel, rd, we, s, flushVal);
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 5'd0, 1'b0, '0, 1'b0);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (scoreboard.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard drained", 64'(scoreboard.size()), 64'd0);
    endtask

    // Monitor: compares delivered beats in order and checks that stalled outputs hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall && bus.out_valid) begin
                checkOutput("stall data hold", 64'(bus.out_data), 64'(prevOut.data));
                checkOutput("stall rd hold", 64'(bus.out_rd), 64'(prevOut.rd));
                checkOutput("stall we hold", 64'(bus.out_we), 64'(prevOut.we));
                checkOutput("stall illegal hold", 64'(bus.out_illegal), 64'(prevOut.ill));
            end
            if (bus.out_valid && bus.out_ready) begin
                popCount++;
                if (scoreboard.size() == 0) begin
                    checkOutput("unexpected beat", 64'd1, 64'd0);
                end else begin
                    monExp = scoreboard.pop_front();
                    checkOutput("beat data", 64'(bus.out_data), 64'(monExp.data));
                    checkOutput("beat rd", 64'(bus.out_rd), 64'(monExp.rd));
                    checkOutput("beat we", 64'(bus.out_we), 64'(monExp.we));
                    checkOutput("beat illegal", 64'(bus.out_illegal), 64'(monExp.ill));
                end
            end
            prevStall    = bus.out_valid && !bus.out_ready;
            prevOut.data = bus.out_data;
            prevOut.rd   = bus.out_rd;
            prevOut.we   = bus.out_we;
            prevOut.ill  = bus.out_illegal;
        end
    end

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_src    = '0;
        bus.in_rd     = 5'd0;
        bus.in_we     = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset out_data", 64'(bus.out_data), 64'd0);
        checkOutput("reset out_we", 64'(bus.out_we), 64'd0);
        checkOutput("reset out_illegal", 64'(bus.out_illegal), 64'd0);
        checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("reset err_cnt", 64'(bus.err_cnt), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Legal select with one-cycle latency.
        bus.out_ready = 1'b1;
        src = randSrc();
        src[3*WIDTH +: WIDTH] = 32'hDEADBEEF;
        applyStimulus(1'b1, 3'd3, 5'd7, 1'b1, src, 1'b0);
        idle();
        @(negedge clk);
        checkOutput("legal out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("legal out_data", 64'(bus.out_data), 64'hDEADBEEF);
        checkOutput("legal out_we", 64'(bus.out_we), 64'd1);
        checkOutput("legal out_rd", 64'(bus.out_rd), 64'd7);

        // Illegal select.
        applyStimulus(1'b1, 3'd6, 5'd4, 1'b1, randSrc(), 1'b0);
        idle();
        @(negedge clk);
        checkOutput("illegal out_data", 64'(bus.out_data), 64'd0);
        checkOutput("illegal out_we", 64'(bus.out_we), 64'd0);
        checkOutput("illegal flag", 64'(bus.out_illegal), 64'd1);
        checkOutput("illegal err_cnt", 64'(bus.err_cnt), 64'd1);

        // rd of zero suppresses the write but keeps the data.
        src = randSrc();
        applyStimulus(1'b1, 3'd2, 5'd0, 1'b1, src, 1'b0);
        idle();
        @(negedge clk);
        checkOutput("rd0 out_we", 64'(bus.out_we), 64'd0);
        checkOutput("rd0 out_data", 64'(bus.out_data), 64'(src[2*WIDTH +: WIDTH]));
        waitDrain(10);

        // Back-pressure: A, B fill main and skid, C waits.
        idle();
        bus.out_ready = 1'b0;
        popBase = popCount;
        srcA = randSrc();
        srcB = randSrc();
        srcC = randSrc();
        applyStimulus(1'b1, 3'd0, 5'd1, 1'b1, srcA, 1'b0);
        applyStimulus(1'b1, 3'd1, 5'd2, 1'b1, srcB, 1'b0);
        applyStimulus(1'b1, 3'd4, 5'd3, 1'b1, srcC, 1'b0);
        checkOutput("full in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("queued beats", 64'(scoreboard.size()), 64'd2);
        applyStimulus(1'b1, 3'd4, 5'd3, 1'b1, srcC, 1'b0);
        checkOutput("stalled out_data", 64'(bus.out_data), 64'(srcA[0 +: WIDTH]));
        applyStimulus(1'b1, 3'd4, 5'd3, 1'b1, srcC, 1'b0);
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 3'd4, 5'd3, 1'b1, srcC, 1'b0);
        idle();
        waitDrain(20);
        checkOutput("delivered count", 64'(popCount - popBase), 64'd3);

        // Flush with both entries full and a beat offered.
        idle();
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 3'd1, 5'd5, 1'b1, randSrc(), 1'b0);
        applyStimulus(1'b1, 3'd4, 5'd6, 1'b1, randSrc(), 1'b0);
        applyStimulus(1'b1, 3'd7, 5'd3, 1'b1, randSrc(), 1'b1);
        idle();
        scoreboard.delete();
        @(negedge clk);
        checkOutput("flush out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("flush in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("flush err_cnt", 64'(bus.err_cnt), 64'd1);

        // Flush on an empty stage must override an illegal accept.
        applyStimulus(1'b1, 3'd7, 5'd3, 1'b1, randSrc(), 1'b1);
        idle();
        @(negedge clk);
        checkOutput("flush accept out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("flush accept err_cnt", 64'(bus.err_cnt), 64'd1);

        // Saturation of the error counter.
        idle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, SELW'(5 + (i % 3)), 5'(i % 32), 1'b1, randSrc(), 1'b0);
        end
        idle();
        waitDrain(20);
        checkOutput("err_cnt saturate", 64'(bus.err_cnt), 64'd255);

        // Asynchronous reset with both entries full.
        idle();
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 3'd0, 5'd9, 1'b1, randSrc(), 1'b0);
        applyStimulus(1'b1, 3'd1, 5'd10, 1'b1, randSrc(), 1'b0);
        idle();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("async reset out_data", 64'(bus.out_data), 64'd0);
        checkOutput("async reset out_rd", 64'(bus.out_rd), 64'd0);
        checkOutput("async reset in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("async reset err_cnt", 64'(bus.err_cnt), 64'd0);
        scoreboard.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        src = randSrc();
        driveBeat(1'b1, 3'd4, 5'd11, 1'b1, src, 1'b0);
        idle();
        @(negedge clk);
        checkOutput("post reset out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("post reset out_data", 64'(bus.out_data), 64'(src[4*WIDTH +: WIDTH]));
        waitDrain(10);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/wb_select_stage.md
WB_SELECT_STAGE -- requirements
Module: wb_select_stage

Interface
REQ-001 Parameter WIDTH, default 32, data width of every source and of out_data.
REQ-002 Parameter NSRC, default 5, number of writeback sources (range 2..8).
REQ-003 Parameter SELW, default 3, select width; SHALL satisfy 2**SELW >= NSRC.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous discard of all buffered beats.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  stage can accept a beat this cycle.
REQ-009 in_sel  input  SELW  source index for this beat.
REQ-010 in_src  input  NSRC*WIDTH  packed sources; source i at bits [i*WIDTH +: WIDTH].
REQ-011 in_rd  input  5  destination register index.
REQ-012 in_we  input  1  requested register write enable.
REQ-013 out_valid  output  1  downstream beat present.
REQ-014 out_ready  input  1  downstream accepts beat.
REQ-015 out_data  output  WIDTH  selected writeback value.
REQ-016 out_rd  output  5  destination register index.
REQ-017 out_we  output  1  qualified write enable.
REQ-018 out_illegal  output  1  current out beat carried an out-of-range select.
REQ-019 err_cnt  output  8  count of accepted illegal-select beats.

Function
REQ-020 Accept SHALL occur when in_valid && in_ready && !flush; mux selection SHALL be evaluated at accept and the result captured, so in_src may change after accept.
REQ-021 Legal select (in_sel < NSRC): captured data SHALL equal source in_sel.
REQ-022 Illegal select (in_sel >= NSRC): captured data SHALL be 0, illegal flag 1, we 0; no latch, no X.
REQ-023 Captured we SHALL be in_we && (in_rd != 0) && legal select.
REQ-024 Storage SHALL be two entries: main (drives outputs) and skid; beats SHALL leave in acceptance order.
REQ-025 in_ready SHALL equal !skid_valid (registered state only, no combinational path from out_ready).
REQ-026 Latency: beat accepted in cycle N with main empty, or main draining in N, SHALL appear on outputs in cycle N+1.
REQ-027 Main full and not draining, accept: beat SHALL go to skid; in_ready low next cycle.
REQ-028 Main draining, skid full: main SHALL load skid, skid clears; no accept possible that cycle.
REQ-029 Main draining, skid empty, accept: main SHALL load new beat; sustained throughput 1 beat/cycle with out_ready high.
REQ-030 While out_valid && !out_ready, out_data/out_rd/out_we/out_illegal SHALL hold stable.
REQ-031 flush SHALL clear main and skid valid next cycle, override simultaneous accept and drain, and leave err_cnt unchanged.
REQ-032 err_cnt SHALL increment by 1 per accepted illegal beat and saturate at 255.

Reset
REQ-033 While rst_n low: out_valid 0, out_data 0, out_rd 0, out_we 0, out_illegal 0, err_cnt 0, skid empty, in_ready 1.
REQ-034 Reset assertion mid-transfer SHALL drop all buffered beats immediately (asynchronous); first accept possible on first rising edge with rst_n high.

Verification
REQ-035 NSRC=5, in_sel=3, source3=0xDEADBEEF, in_rd=7, in_we=1, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_we=1.
REQ-036 in_sel=6 (illegal), in_we=1, rd=4 -> out_data=0, out_we=0, out_illegal=1, err_cnt 0->1; 300 illegal beats -> err_cnt=255.
REQ-037 in_rd=0, legal select, in_we=1 -> out_we=0, out_data still equals selected source.
REQ-038 out_ready=0, three back-to-back beats A,B,C -> A,B accepted, in_ready=0, C held; out_ready=1 -> A,B,C delivered in order, no loss or duplicate.
REQ-039 Main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, beat dropped, err_cnt unchanged.
REQ-040 rst_n pulsed low with both entries full -> outputs 0 immediately, in_ready=1; beat after release delivered with 1-cycle latency.
